gmii_rx_framer: RTL



---
 rtl/gmii_rx_framer_if.sv | 27 ++
 rtl/gmii_rx_framer.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/gmii_rx_framer_if.sv
// Bundles the GMII receive pins and the framed byte-stream/status outputs of gmii_rx_framer.
// slave: the framer's view. master: the view of whatever drives the PHY side and consumes the stream.
interface gmii_rx_framer_if;
  logic [7:0] gmii_rxd;
  logic       gmii_rx_dv;
  logic       gmii_rx_er;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid;
  logic       m_axis_tlast;
  logic       m_axis_tuser;
  logic       stat_frame_good;
  logic       stat_err_fcs;
  logic       stat_err_len;
  logic       stat_err_phy;

  modport master (
    output gmii_rxd, gmii_rx_dv, gmii_rx_er,
    input  m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser,
    input  stat_frame_good, stat_err_fcs, stat_err_len, stat_err_phy
  );

  modport slave (
    input  gmii_rxd, gmii_rx_dv, gmii_rx_er,
    output m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser,
    output stat_frame_good, stat_err_fcs, stat_err_len, stat_err_phy
  );
endinterface

// File: rtl/gmii_rx_framer.sv
// GMII receive framer: preamble/SFD strip, CRC-32 and length checks, byte stream with tlast/tuser.
// Define GMII_RX_FCS_STRIP_EN to remove the 4 FCS bytes from the output stream.
module gmii_rx_framer #(
  parameter int MIN_FRAME_LEN = 64,
  parameter int MAX_FRAME_LEN = 1518
) (
  input  logic            gmii_rx_clk,
  input  logic            reset,
  gmii_rx_framer_if.slave bus
);

`ifdef GMII_RX_FCS_STRIP_EN
  localparam int DLY_N = 5;
`else
  localparam int DLY_N = 1;
`endif

  // Standard Ethernet CRC-32 (reflected) and its good-frame residue with FCS included.
  localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
  localparam logic [10:0] LEN_MIN     = 11'(MIN_FRAME_LEN);
  localparam logic [10:0] LEN_MAX     = 11'(MAX_FRAME_LEN);
  localparam logic [10:0] LEN_SAT     = 11'(MAX_FRAME_LEN + 1);
  localparam logic [10:0] LINE_DEPTH  = 11'(DLY_N);

  typedef enum logic [1:0] {WAIT_IDLE, IDLE, PREAMBLE, DATA} state_t;

  state_t      state_q, state_d;
  logic [7:0]  rxd_q;
  logic        dv_q, er_q;
  logic [31:0] crc_q, crc_d;
  logic [10:0] cnt_q, cnt_d;
  logic        phy_q, phy_d;
  logic [7:0]  dl_q [DLY_N];
  logic [7:0]  dl_d [DLY_N];
  logic [7:0]  tdata_q, tdata_d;
  logic        tvalid_q, tvalid_d, tlast_q, tlast_d, tuser_q, tuser_d;
  logic        good_q, good_d, efcs_q, efcs_d, elen_q, elen_d, ephy_q, ephy_d;
  logic        line_full, err_fcs, err_len;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'd0, d};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
    end
    return r;
  endfunction

  assign line_full = (cnt_q >= LINE_DEPTH);
  assign err_fcs   = (crc_q != CRC_RESIDUE);
  assign err_len   = (cnt_q < LEN_MIN) || (cnt_q > LEN_MAX);

  always_comb begin
    state_d  = state_q;
    crc_d    = crc_q;
    cnt_d    = cnt_q;
    phy_d    = phy_q;
    dl_d     = dl_q;
    tdata_d  = 8'd0;
    tvalid_d = 1'b0;
    tlast_d  = 1'b0;
    tuser_d  = 1'b0;
    good_d   = 1'b0;
    efcs_d   = 1'b0;
    elen_d   = 1'b0;
    ephy_d   = 1'b0;
    case (state_q)
      WAIT_IDLE: begin
        if (!dv_q) state_d = IDLE;
      end
      IDLE: begin
        if (dv_q) state_d = (rxd_q == 8'h55) ? PREAMBLE : WAIT_IDLE;
      end
      PREAMBLE: begin
        if (!dv_q) begin
          state_d = IDLE;
        end else if (er_q) begin
          state_d = WAIT_IDLE;
        end else if (rxd_q == 8'hD5) begin
          state_d = DATA;
          crc_d   = 32'hFFFF_FFFF;
          cnt_d   = 11'd0;
          phy_d   = 1'b0;
        end else if (rxd_q != 8'h55) begin
          state_d = WAIT_IDLE;
        end
      end
      DATA: begin
        if (dv_q) begin
          crc_d = crc_byte(crc_q, rxd_q);
          if (cnt_q != LEN_SAT) cnt_d = cnt_q + 11'd1;
          if (er_q) phy_d = 1'b1;
          if (line_full) begin
            tvalid_d = 1'b1;
            tdata_d  = dl_q[DLY_N-1];
          end
          dl_d[0] = rxd_q;
          for (int i = 1; i < DLY_N; i++) dl_d[i] = dl_q[i-1];
        end else begin
          // Frame end: the oldest held byte closes the stream; younger bytes (FCS when stripping) are dropped.
          state_d = IDLE;
          if (line_full) begin
            tvalid_d = 1'b1;
            tlast_d  = 1'b1;
            tdata_d  = dl_q[DLY_N-1];
            tuser_d  = err_fcs | err_len | phy_q;
          end
          efcs_d = err_fcs;
          elen_d = err_len;
          ephy_d = phy_q;
          good_d = ~(err_fcs | err_len | phy_q);
        end
      end
      default: state_d = WAIT_IDLE;
    endcase
  end

  always_ff @(posedge gmii_rx_clk) begin
    if (reset) begin
      rxd_q    <= 8'd0;
      dv_q     <= 1'b0;
      er_q     <= 1'b0;
      state_q  <= WAIT_IDLE;
      crc_q    <= 32'hFFFF_FFFF;
      cnt_q    <= 11'd0;
      phy_q    <= 1'b0;
      for (int i = 0; i < DLY_N; i++) dl_q[i] <= 8'd0;
      tdata_q  <= 8'd0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      tuser_q  <= 1'b0;
      good_q   <= 1'b0;
      efcs_q   <= 1'b0;
      elen_q   <= 1'b0;
      ephy_q   <= 1'b0;
    end else begin
      rxd_q    <= bus.gmii_rxd;
      dv_q     <= bus.gmii_rx_dv;
      er_q     <= bus.gmii_rx_er;
      state_q  <= state_d;
      crc_q    <= crc_d;
      cnt_q    <= cnt_d;
      phy_q    <= phy_d;
      dl_q     <= dl_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
      tuser_q  <= tuser_d;
      good_q   <= good_d;
      efcs_q   <= efcs_d;
      elen_q   <= elen_d;
      ephy_q   <= ephy_d;
    end
  end

  assign bus.m_axis_tdata    = tdata_q;
  assign bus.m_axis_tvalid   = tvalid_q;
  assign bus.m_axis_tlast    = tlast_q;
  assign bus.m_axis_tuser    = tuser_q;
  assign bus.stat_frame_good = good_q;
  assign bus.stat_err_fcs    = efcs_q;
  assign bus.stat_err_len    = elen_q;
  assign bus.stat_err_phy    = ephy_q;

endmodule
